// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable timer block.
//   ch_state_e    : per-channel operating state
//   SEC_MAX       : last valid seconds value
//   SEC_W         : seconds field width
//   calc_max_min  : largest displayable minutes value for a given field width
//   calc_ch_w     : channel-select width for a given channel count
package timer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StRun,
    StPause,
    StExpired
  } ch_state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_CAP = 99;

  // Minutes saturate at two display digits even when the field could hold more.
  function automatic int unsigned calc_max_min(input int unsigned min_w);
    int unsigned full;
    full = (min_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << min_w) - 32'd1);
    return (full < MIN_CAP) ? full : MIN_CAP;
  endfunction

  function automatic int unsigned calc_ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One independent countdown/count-up timer channel.
//   clk, rst_n        : clock, synchronous active-low reset
//   tick_i            : 1 kHz time-base strobe
//   start_i .. inc_sec_i : one-cycle command strobes already decoded for this channel
//   mode_up_i         : direction, latched on start from IDLE/SET
//   reload_en_i       : auto-reload for down mode, latched on start from IDLE/SET
//   minutes_o, seconds_o : current time
//   running_o, expired_o, blink_o : registered status bits
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned MIN_W         = 7,
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned BLINK_HALF    = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             inc_min_i,
  input  logic             inc_sec_i,
  input  logic             mode_up_i,
  input  logic             reload_en_i,
  output logic [MIN_W-1:0] minutes_o,
  output logic [SEC_W-1:0] seconds_o,
  output logic             running_o,
  output logic             expired_o,
  output logic             blink_o
);

  localparam int unsigned MaxMin = calc_max_min(MIN_W);
  localparam int unsigned SubW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BlkW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [MIN_W-1:0] MinLast = MIN_W'(MaxMin);
  localparam logic [SEC_W-1:0] SecLast = SEC_W'(SEC_MAX);
  localparam logic [SubW-1:0]  SubLast = SubW'(TICKS_PER_SEC - 1);
  localparam logic [BlkW-1:0]  BlkLast = BlkW'(BLINK_HALF - 1);

  ch_state_e        state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d, pre_min_q, pre_min_d;
  logic [SEC_W-1:0] sec_q, sec_d, pre_sec_q, pre_sec_d;
  logic [SubW-1:0]  sub_q, sub_d;
  logic [BlkW-1:0]  blk_cnt_q, blk_cnt_d;
  logic             mode_up_q, mode_up_d;
  logic             reload_q, reload_d;
  logic             blink_q, blink_d;
  logic             running_q, expired_q;

  logic             editable;
  logic             cmd_start, cmd_stop, cmd_inc;
  logic             at_zero;
  logic             reload_hit;
  logic [MIN_W-1:0] min_n;
  logic [SEC_W-1:0] sec_n;

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    pre_min_d  = pre_min_q;
    pre_sec_d  = pre_sec_q;
    sub_d      = sub_q;
    blk_cnt_d  = blk_cnt_q;
    mode_up_d  = mode_up_q;
    reload_d   = reload_q;
    blink_d    = blink_q;
    reload_hit = 1'b0;
    min_n      = min_q;
    sec_n      = sec_q;

    editable = (state_q == StIdle) || (state_q == StSet) || (state_q == StPause);
    at_zero  = (min_q == '0) && (sec_q == '0);

    // Only the highest-priority strobe survives; lower ones are dropped even if
    // the winner turns out to be a no-op in the current state.
    cmd_start = start_i & ~clear_i;
    cmd_stop  = stop_i & ~start_i & ~clear_i;
    cmd_inc   = (inc_min_i | inc_sec_i) & ~stop_i & ~start_i & ~clear_i;

    if (clear_i) begin
      state_d   = StIdle;
      min_d     = '0;
      sec_d     = '0;
      pre_min_d = '0;
      pre_sec_d = '0;
      sub_d     = '0;
      blk_cnt_d = '0;
      blink_d   = 1'b0;
    end else if (cmd_start) begin
      case (state_q)
        StIdle, StSet: begin
          // A down count from 00:00 would expire immediately, so refuse it.
          if (mode_up_i || !at_zero) begin
            mode_up_d = mode_up_i;
            reload_d  = reload_en_i;
            pre_min_d = min_q;
            pre_sec_d = sec_q;
            sub_d     = '0;
            state_d   = StRun;
          end
        end
        StPause: state_d = StRun;
        default: ;
      endcase
    end else if (cmd_stop) begin
      if (state_q == StRun) state_d = StPause;
    end else if (cmd_inc && editable) begin
      if (inc_min_i) min_d = (min_q == MinLast) ? '0 : min_q + MIN_W'(1);
      if (inc_sec_i) sec_d = (sec_q == SecLast) ? '0 : sec_q + SEC_W'(1);
      if (state_q != StPause) state_d = StSet;
    end

    // Commands other than clear/stop are no-ops in RUN and EXPIRED, so a tick
    // arriving alongside them is still honoured.
    if (tick_i && !clear_i && !cmd_stop) begin
      if (state_q == StRun) begin
        if (sub_q == SubLast) begin
          sub_d = '0;
          if (mode_up_q) begin
            if (sec_q != SecLast) begin
              sec_n = sec_q + SEC_W'(1);
            end else if (min_q != MinLast) begin
              sec_n = '0;
              min_n = min_q + MIN_W'(1);
            end
            if (min_n == MinLast && sec_n == SecLast) state_d = StExpired;
          end else begin
            if (sec_q != '0) begin
              sec_n = sec_q - SEC_W'(1);
            end else if (min_q != '0) begin
              sec_n = SecLast;
              min_n = min_q - MIN_W'(1);
            end
            if (min_n == '0 && sec_n == '0) begin
              if (reload_q) begin
                min_n      = pre_min_q;
                sec_n      = pre_sec_q;
                reload_hit = 1'b1;
              end else begin
                state_d = StExpired;
              end
            end
          end
          min_d = min_n;
          sec_d = sec_n;
        end else begin
          sub_d = sub_q + SubW'(1);
        end
      end else if (state_q == StExpired) begin
        if (blk_cnt_q == BlkLast) begin
          blk_cnt_d = '0;
          blink_d   = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BlkW'(1);
        end
      end
    end

    // Blink phase restarts lit on every entry into EXPIRED.
    if (state_d == StExpired && state_q != StExpired) begin
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      min_q     <= '0;
      sec_q     <= '0;
      pre_min_q <= '0;
      pre_sec_q <= '0;
      sub_q     <= '0;
      blk_cnt_q <= '0;
      mode_up_q <= 1'b0;
      reload_q  <= 1'b0;
      blink_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pre_min_q <= pre_min_d;
      pre_sec_q <= pre_sec_d;
      sub_q     <= sub_d;
      blk_cnt_q <= blk_cnt_d;
      mode_up_q <= mode_up_d;
      reload_q  <= reload_d;
      blink_q   <= blink_d;
      running_q <= (state_d == StRun);
      expired_q <= (state_d == StExpired) | reload_hit;
    end
  end

  assign minutes_o = min_q;
  assign seconds_o = sec_q;
  assign running_o = running_q;
  assign expired_o = expired_q;
  assign blink_o   = blink_q;

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: N_CH independent timer_channel instances
// sharing one tick and one command port addressed by ch_sel_i.
//   clk, rst_n         : clock, synchronous active-low reset
//   tick_i             : 1 kHz strobe, advances every running channel at once
//   ch_sel_i           : target channel of the command strobes
//   start_i, stop_i, clear_i, inc_min_i, inc_sec_i : command strobes
//   mode_up_i, reload_en_i : start qualifiers
//   minutes_o, seconds_o  : packed per-channel time, channel i at [i*W +: W]
//   running_o, expired_o, blink_o : per-channel status bits
module prog_timer
  import timer_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned MIN_W         = 7,
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned BLINK_HALF    = 500,
  parameter int unsigned CH_W          = calc_ch_w(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_i,
  input  logic [CH_W-1:0]         ch_sel_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic                    inc_min_i,
  input  logic                    inc_sec_i,
  input  logic                    mode_up_i,
  input  logic                    reload_en_i,
  output logic [N_CH*MIN_W-1:0]   minutes_o,
  output logic [N_CH*SEC_W-1:0]   seconds_o,
  output logic [N_CH-1:0]         running_o,
  output logic [N_CH-1:0]         expired_o,
  output logic [N_CH-1:0]         blink_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Selects at or above N_CH match no instance and are thereby ignored.
    logic hit;
    assign hit = (ch_sel_i == CH_W'(i));

    timer_channel #(
      .MIN_W        (MIN_W),
      .TICKS_PER_SEC(TICKS_PER_SEC),
      .BLINK_HALF   (BLINK_HALF)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick_i),
      .start_i    (start_i & hit),
      .stop_i     (stop_i & hit),
      .clear_i    (clear_i & hit),
      .inc_min_i  (inc_min_i & hit),
      .inc_sec_i  (inc_sec_i & hit),
      .mode_up_i  (mode_up_i),
      .reload_en_i(reload_en_i),
      .minutes_o  (minutes_o[i*MIN_W +: MIN_W]),
      .seconds_o  (seconds_o[i*SEC_W +: SEC_W]),
      .running_o  (running_o[i]),
      .expired_o  (expired_o[i]),
      .blink_o    (blink_o[i])
    );
  end

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: stimulus queues the expected per-channel
// view for a given cycle; the monitor pops and compares on the falling edge.
module tb_prog_timer;

  localparam int N_CH  = 4;
  localparam int MIN_W = 7;
  localparam int CH_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  tick = 1'b0;
  logic [CH_W-1:0]       ch_sel = '0;
  logic                  start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic                  inc_min = 1'b0, inc_sec = 1'b0;
  logic                  mode_up = 1'b0, reload_en = 1'b0;
  logic [N_CH*MIN_W-1:0] minutes;
  logic [N_CH*6-1:0]     seconds;
  logic [N_CH-1:0]       running, expired, blink;

  prog_timer #(
    .N_CH(N_CH), .MIN_W(MIN_W), .TICKS_PER_SEC(1000), .BLINK_HALF(500)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .ch_sel_i(ch_sel),
    .start_i(start), .stop_i(stop), .clear_i(clear),
    .inc_min_i(inc_min), .inc_sec_i(inc_sec),
    .mode_up_i(mode_up), .reload_en_i(reload_en),
    .minutes_o(minutes), .seconds_o(seconds),
    .running_o(running), .expired_o(expired), .blink_o(blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    cyc;
    int    ch;
    int    mn;
    int    sc;
    bit    run;
    bit    xp;
    bit    blk;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [MIN_W-1:0] a_mn;
    logic [5:0]       a_sc;
    logic             a_run, a_xp, a_blk;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e     = sb.pop_front();
      a_mn  = minutes[e.ch*MIN_W +: MIN_W];
      a_sc  = seconds[e.ch*6 +: 6];
      a_run = running[e.ch];
      a_xp  = expired[e.ch];
      a_blk = blink[e.ch];
      n_cmp++;
      if (e.cyc != cyc || a_mn !== MIN_W'(e.mn) || a_sc !== 6'(e.sc) ||
          a_run !== e.run || a_xp !== e.xp || a_blk !== e.blk) begin
        n_bad++;
        $display("FAIL %s ch%0d cyc%0d: got %0d:%0d run=%0b exp=%0b blk=%0b, want %0d:%0d run=%0b exp=%0b blk=%0b (due cyc%0d)",
                 e.name, e.ch, cyc, a_mn, a_sc, a_run, a_xp, a_blk,
                 e.mn, e.sc, e.run, e.xp, e.blk, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  // Expected view of one channel after the next clock edge.
  task automatic expect_ch(input string nm, input int ch, input int mn, input int sc,
                           input bit r, input bit x, input bit b);
    exp_t e;
    e.name = nm; e.cyc = cyc + 1; e.ch = ch; e.mn = mn; e.sc = sc;
    e.run = r; e.xp = x; e.blk = b;
    sb.push_back(e);
  endtask

  task automatic cmd(input int ch, input bit st, input bit sp, input bit cl,
                     input bit im, input bit is, input bit mu, input bit re);
    ch_sel = CH_W'(ch);
    start = st; stop = sp; clear = cl; inc_min = im; inc_sec = is;
    mode_up = mu; reload_en = re;
    step();
    start = 1'b0; stop = 1'b0; clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
    mode_up = 1'b0; reload_en = 1'b0;
  endtask

  task automatic do_inc_min(input int ch); cmd(ch, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_inc_sec(input int ch); cmd(ch, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_stop(input int ch);    cmd(ch, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_clear(input int ch);   cmd(ch, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_start(input int ch, input bit mu, input bit re);
    cmd(ch, 1, 0, 0, 0, 0, mu, re);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state
    for (int c = 0; c < N_CH; c++) expect_ch("reset", c, 0, 0, 0, 0, 0);
    step();
    idle(1);
    rst_n = 1'b1;

    // ch0: 01:02 down, no reload -> expires after 62 s
    expect_ch("a_inc_min", 0, 1, 0, 0, 0, 0); do_inc_min(0);
    do_inc_sec(0);
    expect_ch("a_inc_sec", 0, 1, 2, 0, 0, 0); do_inc_sec(0);
    expect_ch("a_start", 0, 1, 2, 1, 0, 0);   do_start(0, 1'b0, 1'b0);
    ticks(999);
    expect_ch("a_1s", 0, 1, 1, 1, 0, 0);      ticks(1);
    ticks(60999);
    expect_ch("a_expire", 0, 0, 0, 0, 1, 1);  ticks(1);
    ticks(498);
    expect_ch("a_blink_hold", 0, 0, 0, 0, 1, 1);   ticks(1);
    expect_ch("a_blink_toggle", 0, 0, 0, 0, 1, 0); ticks(1);
    expect_ch("a_start_in_exp", 0, 0, 0, 0, 1, 0); do_start(0, 1'b1, 1'b0);
    expect_ch("a_inc_in_exp", 0, 0, 0, 0, 1, 0);   do_inc_min(0);
    expect_ch("a_clear", 0, 0, 0, 0, 0, 0);        do_clear(0);
    expect_ch("a_start_zero_down", 0, 0, 0, 0, 0, 0); do_start(0, 1'b0, 1'b0);

    // ch1: 00:03 down with reload
    do_inc_sec(1); do_inc_sec(1);
    expect_ch("b_set", 1, 0, 3, 0, 0, 0);     do_inc_sec(1);
    expect_ch("b_start", 1, 0, 3, 1, 0, 0);   do_start(1, 1'b0, 1'b1);
    ticks(2998);
    expect_ch("b_pre", 1, 0, 1, 1, 0, 0);     ticks(1);
    expect_ch("b_reload", 1, 0, 3, 1, 1, 0);  ticks(1);
    expect_ch("b_pulse_end", 1, 0, 3, 1, 0, 0); idle(1);
    expect_ch("b_stop", 1, 0, 3, 0, 0, 0);    do_stop(1);
    do_clear(1);

    // ch3: field wraps, simultaneous increments, priority
    repeat (98) do_inc_min(3);
    expect_ch("c_min99", 3, 99, 0, 0, 0, 0);  do_inc_min(3);
    expect_ch("c_min_wrap", 3, 0, 0, 0, 0, 0); do_inc_min(3);
    do_inc_min(3);
    repeat (58) do_inc_sec(3);
    expect_ch("c_sec59", 3, 1, 59, 0, 0, 0);  do_inc_sec(3);
    expect_ch("c_sec_wrap", 3, 1, 0, 0, 0, 0); do_inc_sec(3);
    expect_ch("c_both", 3, 2, 1, 0, 0, 0);    cmd(3, 0, 0, 0, 1, 1, 0, 0);
    expect_ch("c_stop_over_inc", 3, 2, 1, 0, 0, 0); cmd(3, 0, 1, 0, 1, 0, 0, 0);
    do_clear(3);

    // ch3: up count hits 99:59 and holds
    repeat (99) do_inc_min(3);
    repeat (58) do_inc_sec(3);
    expect_ch("c_up_start", 3, 99, 58, 1, 0, 0); do_start(3, 1'b1, 1'b0);
    ticks(998);
    expect_ch("c_up_pre", 3, 99, 58, 1, 0, 0);   ticks(1);
    expect_ch("c_up_max", 3, 99, 59, 0, 1, 1);   ticks(1);
    ticks(999);
    expect_ch("c_up_hold", 3, 99, 59, 0, 1, 1);  ticks(1);
    do_clear(3);

    // ch2: up, pause, resume with preserved sub-second count
    expect_ch("d_start", 2, 0, 0, 1, 0, 0);   do_start(2, 1'b1, 1'b0);
    ticks(1499);
    expect_ch("d_1500", 2, 0, 1, 1, 0, 0);    ticks(1);
    expect_ch("d_stop", 2, 0, 1, 0, 0, 0);    do_stop(2);
    ticks(4999);
    expect_ch("d_paused", 2, 0, 1, 0, 0, 0);  ticks(1);
    expect_ch("d_resume", 2, 0, 1, 1, 0, 0);  do_start(2, 1'b0, 1'b0);
    ticks(498);
    expect_ch("d_pre", 2, 0, 1, 1, 0, 0);     ticks(1);
    expect_ch("d_2s", 2, 0, 2, 1, 0, 0);      ticks(1);

    // clear beats start on a running channel
    expect_ch("e_clear_start", 2, 0, 0, 0, 0, 0); cmd(2, 1, 0, 1, 0, 0, 1, 0);

    // reset mid-run, with a tick and a command in flight
    do_inc_min(0); do_start(0, 1'b0, 1'b0);
    do_inc_sec(1); do_start(1, 1'b1, 1'b0);
    ticks(10);
    expect_ch("f_run0", 0, 1, 0, 1, 0, 0);
    expect_ch("f_run1", 1, 0, 1, 1, 0, 0);
    ticks(1);
    for (int c = 0; c < N_CH; c++) expect_ch("f_reset", c, 0, 0, 0, 0, 0);
    rst_n = 1'b0; tick = 1'b1; ch_sel = 2'd2; start = 1'b1; mode_up = 1'b1;
    step();
    rst_n = 1'b1; tick = 1'b0; start = 1'b0; mode_up = 1'b0;
    for (int c = 0; c < N_CH; c++) expect_ch("f_after", c, 0, 0, 0, 0, 0);
    idle(1);

    n_cmp++;
    if (running !== '0) begin
      n_bad++;
      $display("FAIL g_running: got %b, want 0", running);
    end
    n_cmp++;
    if (expired !== '0) begin
      n_bad++;
      $display("FAIL g_expired: got %b, want 0", expired);
    end
    n_cmp++;
    if (blink !== '0) begin
      n_bad++;
      $display("FAIL g_blink: got %b, want 0", blink);
    end
    n_cmp++;
    if (minutes !== '0) begin
      n_bad++;
      $display("FAIL g_minutes: got %h, want 0", minutes);
    end
    n_cmp++;
    if (seconds !== '0) begin
      n_bad++;
      $display("FAIL g_seconds: got %h, want 0", seconds);
    end

    idle(2);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s ch%0d: got never compared, want compare at cyc%0d", e.name, e.ch, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-002 Parameter MIN_W, default 7, minutes field width; MAX_MIN = min(2^MIN_W-1, 99).
REQ-003 Parameter TICKS_PER_SEC, default 1000, tick strobes per second.
REQ-004 Parameter BLINK_HALF, default 500, ticks per blink half-period.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 tick  in  1  one-cycle strobe at 1 kHz, synchronous to clk.
REQ-008 ch_sel  in  CH_W = max(1, clog2(N_CH))  channel addressed by the command inputs.
REQ-009 start, stop, clear, inc_min, inc_sec  in  1 each  one-cycle command strobes for channel ch_sel.
REQ-010 mode_up  in  1  direction latched on start: 1 counts up, 0 counts down.
REQ-011 reload_en  in  1  auto-reload latched on start; applies only to down mode.
REQ-012 minutes  out  N_CH*MIN_W  per-channel minutes; channel i at [i*MIN_W +: MIN_W].
REQ-013 seconds  out  N_CH*6  per-channel seconds, 0..59.
REQ-014 running, expired, blink  out  N_CH each  per-channel status bits.

Function
REQ-015 Each channel is in exactly one state: IDLE, SET, RUN, PAUSE or EXPIRED.
REQ-016 Command priority within one cycle: clear > start > stop > inc_min/inc_sec; lower-priority commands are dropped; commands with ch_sel >= N_CH are ignored.
REQ-017 clear: from any state, time 00:00, sub-second counter 0, preset 00:00, state IDLE, next cycle.
REQ-018 inc_min: in IDLE, SET or PAUSE, minutes+1, wrapping MAX_MIN->0; state becomes SET (PAUSE stays PAUSE); ignored in RUN and EXPIRED.
REQ-019 inc_sec: same gating as inc_min; seconds+1, wrapping 59->0 with no carry into minutes.
REQ-020 inc_min and inc_sec in the same cycle both apply.
REQ-021 start from IDLE/SET: latch mode_up, reload_en; copy current time into preset; clear sub-second counter; enter RUN next cycle.
REQ-022 start in down mode with time 00:00 is ignored.
REQ-023 start from PAUSE: resume RUN with the latched mode and preserved sub-second count; start in RUN or EXPIRED is ignored.
REQ-024 stop: RUN->PAUSE; ignored in all other states.
REQ-025 In RUN, each tick increments the sub-second counter; on reaching TICKS_PER_SEC it resets to 0 and the time steps by one second in the same cycle.
REQ-026 Down step: seconds 0 borrows from minutes and reloads 59.
REQ-027 Down step reaching 00:00: if reload_en, time = preset and stay in RUN, with expired asserted for exactly that one cycle; otherwise enter EXPIRED.
REQ-028 Up step: seconds 59 carries into minutes; on reaching MAX_MIN:59, enter EXPIRED and hold that value.
REQ-029 running = 1 iff state is RUN; expired = 1 in EXPIRED, and for the reload pulse in REQ-027.
REQ-030 blink: 0 outside EXPIRED; on entry to EXPIRED it is 1 and toggles every BLINK_HALF ticks.
REQ-031 Exit from EXPIRED is by clear only.
REQ-032 Outputs are registered; a command's effect is visible on the cycle after its strobe.
REQ-033 Channels are fully independent; a tick advances all RUN channels in the same cycle.

Reset
REQ-034 While rst_n = 0 at a clk edge, every channel goes to IDLE, with time, preset, sub-second counter and blink counter 0.
REQ-035 While rst_n = 0, running, expired and blink are all 0 on the next edge.
REQ-036 Reset overrides any in-flight command or tick, including mid-RUN.

Structure
REQ-037 Package timer_pkg holds the state enum, SEC_MAX = 59, and a function computing MAX_MIN from MIN_W.
REQ-038 One sub-module, timer_channel, implements a single channel.
REQ-039 prog_timer instantiates N_CH timer_channel instances and decodes ch_sel into per-channel command strobes.

Verification
REQ-040 Scenario: ch0 inc_min×1, inc_sec×2, start (down), then 62000 ticks -> 00:00, expired[0]=1, blink[0]=1, running[0]=0.
REQ-041 Scenario: ch1 preset 00:03, reload_en=1, start, then 3000 ticks -> expired[1] pulses for 1 cycle, time reads 00:03, running[1] stays 1.
REQ-042 Scenario: MIN_W=7, minutes 99, inc_min -> minutes 0; seconds 59, inc_sec -> seconds 0 with minutes unchanged.
REQ-043 Scenario: ch2 up mode from 00:00, stop after 1500 ticks, 5000 idle ticks, start, 500 ticks -> reads 00:02.
REQ-044 Scenario: clear and start on the same cycle for a running channel -> IDLE, 00:00, running=0.
REQ-045 Scenario: rst_n=0 for one cycle while two channels are in RUN -> all outputs 0 on the next cycle.
